// File: rtl/msrv32_csr_file.sv
// ---------------------------------------------------------------------------
// msrv32_csr_file
//   Machine-mode CSR register file for the msrv32 RV32I core (Zicsr, M-mode
//   only). It executes CSR instructions and captures trap state
//   (mepc/mcause/mtval). It also runs the MIE/MPIE stack on trap entry and
//   mret, and exports the trap vector, epc and interrupt enable/pending bits.
//
// Ports
//   ms_riscv32_mp_clk_in        core clock
//   ms_riscv32_mp_rst_in        asynchronous active-low reset
//   wr_en_in                    CSR instruction write enable
//   csr_addr_in[11:0]           CSR address (read and write)
//   csr_op_in[2:0]              funct3 (RW/RS/RC and immediate forms)
//   csr_uimm_in[4:0]            zimm for the immediate forms
//   csr_data_in[31:0]           rs1 value for the register forms
//   csr_data_out[31:0]          registered read data
//   pc_in / iadder_in[31:0]     faulting PC / faulting address
//   set_epc_in, set_cause_in    trap state capture strobes
//   i_or_e_in, cause_in[3:0]    interrupt flag and cause code
//   mie_clear_in / mie_set_in   trap entry / mret stack operations
//   instret_inc_in              retire pulse
//   ms_riscv32_mp_{e,t,s}irq_in interrupt request lines
//   ms_riscv32_mp_rc_in[63:0]   real-time counter
//   mie_out, m{e,t,s}ie_out     mstatus.MIE and mie enables
//   m{e,t,s}ip_out              mip pending bits
//   trap_address_out[31:0]      trap handler address
//   epc_out[31:0]               mepc
// ---------------------------------------------------------------------------
module msrv32_csr_file (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [4:0]  csr_uimm_in,
  input  logic [31:0] csr_data_in,
  output logic [31:0] csr_data_out,
  input  logic [31:0] pc_in,
  input  logic [31:0] iadder_in,
  input  logic        set_epc_in,
  input  logic        set_cause_in,
  input  logic        i_or_e_in,
  input  logic [3:0]  cause_in,
  input  logic        mie_clear_in,
  input  logic        mie_set_in,
  input  logic        instret_inc_in,
  input  logic        ms_riscv32_mp_eirq_in,
  input  logic        ms_riscv32_mp_tirq_in,
  input  logic        ms_riscv32_mp_sirq_in,
  input  logic [63:0] ms_riscv32_mp_rc_in,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic        msip_out,
  output logic [31:0] trap_address_out,
  output logic [31:0] epc_out
);

  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_TIME      = 12'hC01;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_TIMEH     = 12'hC81;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  // Storage
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie, mie_mtie, mie_msie;
  logic        mip_meip, mip_mtip, mip_msip;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [31:0] mscratch;
  logic [29:0] mepc;
  logic        mcause_int;
  logic [3:0]  mcause_code;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Derived views
  logic [31:0] mstatus_val;
  logic [31:0] mie_val;
  logic [31:0] mip_val;
  logic [31:0] mtvec_val;
  logic [31:0] mepc_val;
  logic [31:0] mcause_val;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
  assign mip_val     = {20'b0, mip_meip, 3'b0, mip_mtip, 3'b0, mip_msip, 3'b0};
  assign mtvec_val   = {mtvec_base, 1'b0, mtvec_mode};
  assign mepc_val    = {mepc, 2'b00};
  assign mcause_val  = {mcause_int, 27'b0, mcause_code};

  // Read mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (csr_addr_in)
      A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: rdata = '0;
      A_MSTATUS:              rdata = mstatus_val;
      A_MISA:                 rdata = MISA_VALUE;
      A_MIE:                  rdata = mie_val;
      A_MTVEC:                rdata = mtvec_val;
      A_MSCRATCH:             rdata = mscratch;
      A_MEPC:                 rdata = mepc_val;
      A_MCAUSE:               rdata = mcause_val;
      A_MTVAL:                rdata = mtval;
      A_MIP:                  rdata = mip_val;
      A_MCYCLE,   A_CYCLE:    rdata = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:   rdata = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  rdata = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: rdata = minstret[63:32];
      A_TIME:                 rdata = ms_riscv32_mp_rc_in[31:0];
      A_TIMEH:                rdata = ms_riscv32_mp_rc_in[63:32];
      default:                rdata = '0;
    endcase
  end

  // Write data and modify operation
  logic [31:0] wd;
  logic [31:0] new_val;
  logic        csr_we;

  assign wd = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;

  always_comb begin
    new_val = rdata;
    case (csr_op_in[1:0])
      2'b01:   new_val = wd;
      2'b10:   new_val = rdata | wd;
      2'b11:   new_val = rdata & ~wd;
      default: new_val = rdata;
    endcase
  end

  // Addresses with [11:10] == 2'b11 are read-only; op x00 performs no write.
  assign csr_we = wr_en_in && (csr_op_in[1:0] != 2'b00) && (csr_addr_in[11:10] != 2'b11);

  logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
  logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

  assign we_mstatus   = csr_we && (csr_addr_in == A_MSTATUS);
  assign we_mie       = csr_we && (csr_addr_in == A_MIE);
  assign we_mtvec     = csr_we && (csr_addr_in == A_MTVEC);
  assign we_mscratch  = csr_we && (csr_addr_in == A_MSCRATCH);
  assign we_mepc      = csr_we && (csr_addr_in == A_MEPC);
  assign we_mcause    = csr_we && (csr_addr_in == A_MCAUSE);
  assign we_mtval     = csr_we && (csr_addr_in == A_MTVAL);
  assign we_mcycle    = csr_we && (csr_addr_in == A_MCYCLE);
  assign we_mcycleh   = csr_we && (csr_addr_in == A_MCYCLEH);
  assign we_minstret  = csr_we && (csr_addr_in == A_MINSTRET);
  assign we_minstreth = csr_we && (csr_addr_in == A_MINSTRETH);

  // mstatus: trap-side stack operations override a CSR write, clear over set
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (mie_clear_in) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mie_set_in) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (we_mstatus) begin
      mstatus_mie  <= new_val[3];
      mstatus_mpie <= new_val[7];
    end
  end

  // mie, mtvec, mscratch
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mie_meie   <= 1'b0;
      mie_mtie   <= 1'b0;
      mie_msie   <= 1'b0;
      mtvec_base <= '0;
      mtvec_mode <= 1'b0;
      mscratch   <= '0;
    end else begin
      if (we_mie) begin
        mie_meie <= new_val[11];
        mie_mtie <= new_val[7];
        mie_msie <= new_val[3];
      end
      if (we_mtvec) begin
        mtvec_base <= new_val[31:2];
        mtvec_mode <= new_val[0];
      end
      if (we_mscratch) mscratch <= new_val;
    end
  end

  // mip samples the request lines every cycle
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mip_meip <= 1'b0;
      mip_mtip <= 1'b0;
      mip_msip <= 1'b0;
    end else begin
      mip_meip <= ms_riscv32_mp_eirq_in;
      mip_mtip <= ms_riscv32_mp_tirq_in;
      mip_msip <= ms_riscv32_mp_sirq_in;
    end
  end

  // Trap state: capture strobes take priority over CSR writes
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mepc        <= '0;
      mcause_int  <= 1'b0;
      mcause_code <= '0;
      mtval       <= '0;
    end else begin
      if (set_epc_in)   mepc <= pc_in[31:2];
      else if (we_mepc) mepc <= new_val[31:2];

      if (set_cause_in) begin
        mcause_int  <= i_or_e_in;
        mcause_code <= cause_in;
        mtval       <= i_or_e_in ? 32'b0 : iadder_in;
      end else begin
        if (we_mcause) begin
          mcause_int  <= new_val[31];
          mcause_code <= new_val[3:0];
        end
        if (we_mtval) mtval <= new_val;
      end
    end
  end

  // Counters: a write to either half replaces that cycle's increment
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (we_mcycle)       mcycle <= {mcycle[63:32], new_val};
      else if (we_mcycleh) mcycle <= {new_val, mcycle[31:0]};
      else                 mcycle <= mcycle + 64'd1;

      if (we_minstret)         minstret <= {minstret[63:32], new_val};
      else if (we_minstreth)   minstret <= {new_val, minstret[31:0]};
      else if (instret_inc_in) minstret <= minstret + 64'd1;
    end
  end

  // Registered read port: returns the pre-write value on a write cycle
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) csr_data_out <= '0;
    else                       csr_data_out <= rdata;
  end

  // Vectored mode offsets the base only for interrupts
  always_comb begin
    if (mtvec_mode && mcause_int)
      trap_address_out = {mtvec_base, 2'b00} + {26'b0, mcause_code, 2'b00};
    else
      trap_address_out = {mtvec_base, 2'b00};
  end

  assign epc_out  = mepc_val;
  assign mie_out  = mstatus_mie;
  assign meie_out = mie_meie;
  assign mtie_out = mie_mtie;
  assign msie_out = mie_msie;
  assign meip_out = mip_meip;
  assign mtip_out = mip_mtip;
  assign msip_out = mip_msip;

endmodule

// File: tb/tb_msrv32_csr_file.sv
// ---------------------------------------------------------------------------
// tb_msrv32_csr_file
//   Directed self-checking bench for msrv32_csr_file. Inputs change 1 time
//   unit after a rising edge. Outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_msrv32_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_data;
  logic [31:0] csr_data_out;
  logic [31:0] pc, iadder;
  logic        set_epc, set_cause, i_or_e;
  logic [3:0]  cause;
  logic        mie_clear, mie_set, instret_inc;
  logic        eirq, tirq, sirq;
  logic [63:0] rc;
  logic        mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o;
  logic [31:0] trap_addr, epc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  msrv32_csr_file dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_in  (rst_n),
    .wr_en_in              (wr_en),
    .csr_addr_in           (csr_addr),
    .csr_op_in             (csr_op),
    .csr_uimm_in           (csr_uimm),
    .csr_data_in           (csr_data),
    .csr_data_out          (csr_data_out),
    .pc_in                 (pc),
    .iadder_in             (iadder),
    .set_epc_in            (set_epc),
    .set_cause_in          (set_cause),
    .i_or_e_in             (i_or_e),
    .cause_in              (cause),
    .mie_clear_in          (mie_clear),
    .mie_set_in            (mie_set),
    .instret_inc_in        (instret_inc),
    .ms_riscv32_mp_eirq_in (eirq),
    .ms_riscv32_mp_tirq_in (tirq),
    .ms_riscv32_mp_sirq_in (sirq),
    .ms_riscv32_mp_rc_in   (rc),
    .mie_out               (mie_o),
    .meie_out              (meie_o),
    .mtie_out              (mtie_o),
    .msie_out              (msie_o),
    .meip_out              (meip_o),
    .mtip_out              (mtip_o),
    .msip_out              (msip_o),
    .trap_address_out      (trap_addr),
    .epc_out               (epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle CSR instruction; immediate forms drive rs1 with all ones
  task automatic csr_wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_addr = a;
    csr_op   = op;
    csr_uimm = d[4:0];
    csr_data = op[2] ? 32'hFFFF_FFFF : d;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    wr_en    = 1'b0;
    tick();
    check(tag, csr_data_out, exp);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; csr_addr = '0; csr_op = '0; csr_uimm = '0; csr_data = '0;
    pc = '0; iadder = '0; set_epc = 1'b0; set_cause = 1'b0; i_or_e = 1'b0; cause = '0;
    mie_clear = 1'b0; mie_set = 1'b0; instret_inc = 1'b0;
    eirq = 1'b0; tirq = 1'b0; sirq = 1'b0; rc = '0;

    // Reset state
    #12;
    check("rst_data_out", csr_data_out, 32'h0);
    check("rst_mie_out", {31'b0, mie_o}, 32'h0);
    check("rst_trap_addr", trap_addr, 32'h0);
    check("rst_epc", epc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    csr_rd("mstatus_reset", 12'h300, 32'h0000_1800);

    // mstatus / mie / mtvec
    csr_wr(12'h300, 3'b001, 32'hDEAD_BEEF);
    csr_rd("mstatus_rw", 12'h300, 32'h0000_1888);
    check("mie_out_set", {31'b0, mie_o}, 32'h1);
    csr_wr(12'h304, 3'b001, 32'hCAFE_BABE);
    csr_rd("mie_rw", 12'h304, 32'h0000_0888);
    check("mie_enables", {29'b0, meie_o, mtie_o, msie_o}, 32'h7);
    csr_wr(12'h305, 3'b001, 32'h0000_ABCD);
    csr_rd("mtvec_rw", 12'h305, 32'h0000_ABCD);
    csr_rd("misa", 12'h301, 32'h4000_0100);

    // Trap capture
    pc = 32'h4444_ABCD; set_epc = 1'b1; tick(); set_epc = 1'b0;
    check("epc_out", epc, 32'h4444_ABCC);
    csr_rd("mepc_read", 12'h341, 32'h4444_ABCC);
    i_or_e = 1'b1; cause = 4'd11; iadder = 32'h1234_5678; set_cause = 1'b1; tick(); set_cause = 1'b0;
    csr_rd("mcause_int", 12'h342, 32'h8000_000B);
    csr_rd("mtval_int", 12'h343, 32'h0);
    check("trap_vectored", trap_addr, 32'h0000_ABF8);
    i_or_e = 1'b0; cause = 4'd2; set_cause = 1'b1; tick(); set_cause = 1'b0;
    csr_rd("mcause_exc", 12'h342, 32'h0000_0002);
    csr_rd("mtval_exc", 12'h343, 32'h1234_5678);
    check("trap_direct", trap_addr, 32'h0000_ABCC);
    // set_epc beats a same-cycle write to mepc
    pc = 32'h0000_0100; set_epc = 1'b1;
    csr_wr(12'h341, 3'b001, 32'h0000_0200);
    set_epc = 1'b0;
    check("epc_priority", epc, 32'h0000_0100);

    // MIE/MPIE stack
    csr_wr(12'h300, 3'b001, 32'h0000_0008);
    mie_clear = 1'b1; tick(); mie_clear = 1'b0;
    check("mie_clear_mie", {31'b0, mie_o}, 32'h0);
    csr_rd("mie_clear_mstatus", 12'h300, 32'h0000_1880);
    mie_set = 1'b1; tick(); mie_set = 1'b0;
    check("mie_set_mie", {31'b0, mie_o}, 32'h1);
    csr_rd("mie_set_mstatus", 12'h300, 32'h0000_1888);
    mie_clear = 1'b1;
    csr_wr(12'h300, 3'b001, 32'h0);
    mie_clear = 1'b0;
    csr_rd("clear_over_write", 12'h300, 32'h0000_1880);
    mie_clear = 1'b1; mie_set = 1'b1; tick(); mie_clear = 1'b0; mie_set = 1'b0;
    csr_rd("clear_over_set", 12'h300, 32'h0000_1800);
    mie_set = 1'b1; tick(); mie_set = 1'b0;
    csr_rd("set_after_clear", 12'h300, 32'h0000_1880);

    // Set/clear forms
    csr_wr(12'h300, 3'b110, 32'h8);
    csr_rd("rsi_mstatus", 12'h300, 32'h0000_1888);
    csr_wr(12'h300, 3'b111, 32'h8);
    csr_rd("rci_mstatus", 12'h300, 32'h0000_1880);
    csr_wr(12'h300, 3'b011, 32'h80);
    csr_rd("rc_mstatus", 12'h300, 32'h0000_1800);
    csr_wr(12'h300, 3'b100, 32'hFFFF_FFFF);
    csr_rd("op100_nowrite", 12'h300, 32'h0000_1800);
    csr_wr(12'h340, 3'b001, 32'h55AA_1234);
    csr_rd("mscratch_rw", 12'h340, 32'h55AA_1234);
    csr_wr(12'h340, 3'b010, 32'h0000_000F);
    csr_rd("mscratch_rs", 12'h340, 32'h55AA_123F);
    csr_wr(12'h340, 3'b011, 32'h0000_0030);
    csr_rd("mscratch_rc", 12'h340, 32'h55AA_120F);
    csr_wr(12'hF14, 3'b001, 32'hFFFF_FFFF);
    csr_rd("mhartid_ro", 12'hF14, 32'h0);
    csr_wr(12'h7C0, 3'b001, 32'hFFFF_FFFF);
    csr_rd("unimpl", 12'h7C0, 32'h0);

    // Counters
    csr_wr(12'hB00, 3'b001, 32'd5);
    csr_rd("mcycle_w5", 12'hB00, 32'd5);
    csr_rd("mcycle_6", 12'hB00, 32'd6);
    csr_rd("cycle_alias", 12'hC00, 32'd7);
    csr_rd("mcycleh", 12'hB80, 32'd0);
    instret_inc = 1'b1; tick(); tick(); tick(); instret_inc = 1'b0;
    csr_rd("minstret_3", 12'hB02, 32'd3);
    csr_rd("instret_alias", 12'hC02, 32'd3);
    instret_inc = 1'b1;
    csr_wr(12'hB02, 3'b001, 32'd10);
    instret_inc = 1'b0;
    csr_rd("minstret_write_wins", 12'hB02, 32'd10);
    rc = 64'h0000_0001_0000_0002;
    csr_rd("time_lo", 12'hC01, 32'd2);
    csr_rd("time_hi", 12'hC81, 32'd1);

    // Interrupt pending sampling
    eirq = 1'b1;
    check("meip_before_edge", {31'b0, meip_o}, 32'h0);
    tick();
    check("meip_after_edge", {31'b0, meip_o}, 32'h1);
    tirq = 1'b1;
    csr_rd("mip_read", 12'h344, 32'h0000_0800);
    csr_rd("mip_read2", 12'h344, 32'h0000_0880);

    // Mid-run asynchronous reset
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", csr_data_out, 32'h0);
    check("async_rst_epc", epc, 32'h0);
    check("async_rst_trap", trap_addr, 32'h0);
    check("async_rst_irq", {25'b0, mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o}, 32'h0);
    tirq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("meip_after_rst", {31'b0, meip_o}, 32'h1);
    csr_rd("mstatus_after_rst", 12'h300, 32'h0000_1800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
